// File: rtl/ibex_pkg.sv
// Shared types for the CSR bank controller: operation encoding and index width.
package ibex_pkg;

    typedef enum logic [1:0] {
        CSR_OP_READ  = 2'd0,
        CSR_OP_WRITE = 2'd1,
        CSR_OP_SET   = 2'd2,
        CSR_OP_CLEAR = 2'd3
    } csr_op_e;

    localparam int unsigned CSR_BANK_IDX_W = 5;

    function automatic logic csr_op_writes(csr_op_e op);
        return op != CSR_OP_READ;
    endfunction

endpackage

// File: rtl/ibex_csr.sv
// Single CSR with optional inverted shadow copy; rd_error_o flags a copy mismatch.
module ibex_csr #(
    parameter int unsigned      Width      = 32,
    parameter bit               ShadowCopy = 1'b0,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] wr_data_i,
    input  logic             wr_en_i,
    output logic [Width-1:0] rd_data_o,
    output logic             rd_error_o
);

    logic [Width-1:0] r_q;
    logic [Width-1:0] r_shadow;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q      <= ResetValue;
            r_shadow <= ~ResetValue;
        end else if (wr_en_i) begin
            r_q      <= wr_data_i;
            r_shadow <= ~wr_data_i;
        end
    end

    assign rd_data_o  = r_q;
    assign rd_error_o = ShadowCopy ? (r_q != ~r_shadow) : 1'b0;

endmodule

// File: rtl/ibex_csr_bank_arb.sv
// Two-way round-robin arbiter; priority flips to the loser after every grant.
module ibex_csr_bank_arb (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output logic       winner_o
);

    // r_prio: 0 = core has priority, 1 = debug has priority
    logic r_prio;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) gnt_o = r_prio ? 2'b10 : 2'b01;
    end

    assign winner_o = gnt_o[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     r_prio <= 1'b0;
        else if (|gnt_o) r_prio <= gnt_o[0];
    end

endmodule

// File: rtl/ibex_csr_bank_ctrl.sv
// Arbitrated read-modify-write controller over a bank of shadowed CSRs.
// Optional background integrity scrubber enabled by IBEX_CSR_BANK_SCRUB_EN.
module ibex_csr_bank_ctrl import ibex_pkg::*; #(
    parameter int unsigned               Width      = 32,
    parameter int unsigned               NumCsr     = 8,
    parameter bit                        ShadowCopy = 1'b1,
    parameter logic [NumCsr*Width-1:0]   ResetVals  = '0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [1:0]                           req_i,
    input  logic [1:0][1:0]                      op_i,
    input  logic [1:0][CSR_BANK_IDX_W-1:0]       addr_i,
    input  logic [1:0][Width-1:0]                wdata_i,
    output logic [1:0]                           gnt_o,
    output logic [1:0]                           rvalid_o,
    output logic [Width-1:0]                     rdata_o,
    output logic                                 err_o,
    output logic                                 alert_o,
    output logic [CSR_BANK_IDX_W-1:0]            alert_idx_o
);

    logic [1:0]                   w_gnt;
    logic                         w_win;
    logic                         w_any;
    csr_op_e                      w_op;
    logic [CSR_BANK_IDX_W-1:0]    w_addr;
    logic [Width-1:0]             w_wdata;
    logic                         w_addr_ok;
    logic [Width-1:0]             w_old;
    logic                         w_old_err;
    logic [Width-1:0]             w_new;
    logic                         w_commit;
    logic [NumCsr-1:0][Width-1:0] w_rd_data;
    logic [NumCsr-1:0]            w_rd_error;
    logic [NumCsr-1:0]            w_wr_en;
    logic                         w_scrub_hit;
    logic [CSR_BANK_IDX_W-1:0]    w_scrub_idx;

    logic [1:0]                   r_rvalid;
    logic [Width-1:0]             r_rdata;
    logic                         r_err;
    logic                         r_alert;
    logic [CSR_BANK_IDX_W-1:0]    r_alert_idx;

    ibex_csr_bank_arb u_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .gnt_o    (w_gnt),
        .winner_o (w_win)
    );

    assign w_any     = |w_gnt;
    assign w_op      = csr_op_e'(op_i[w_win]);
    assign w_addr    = addr_i[w_win];
    assign w_wdata   = wdata_i[w_win];
    assign w_addr_ok = 32'(w_addr) < NumCsr;

    // Out-of-range addresses match no entry, so they read as zero without error bit
    always_comb begin
        w_old     = '0;
        w_old_err = 1'b0;
        for (int i = 0; i < NumCsr; i++) begin
            if (w_addr == CSR_BANK_IDX_W'(i)) begin
                w_old     = w_rd_data[i];
                w_old_err = w_rd_error[i];
            end
        end
    end

    always_comb begin
        case (w_op)
            CSR_OP_WRITE: w_new = w_wdata;
            CSR_OP_SET:   w_new = w_old | w_wdata;
            CSR_OP_CLEAR: w_new = w_old & ~w_wdata;
            default:      w_new = w_old;
        endcase
    end

    assign w_commit = w_any && w_addr_ok && csr_op_writes(w_op) && !w_old_err;

    for (genvar i = 0; i < NumCsr; i++) begin : g_csr
        assign w_wr_en[i] = w_commit && (w_addr == CSR_BANK_IDX_W'(i));

        ibex_csr #(
            .Width      (Width),
            .ShadowCopy (ShadowCopy),
            .ResetValue (ResetVals[i*Width +: Width])
        ) u_csr (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .wr_data_i  (w_new),
            .wr_en_i    (w_wr_en[i]),
            .rd_data_o  (w_rd_data[i]),
            .rd_error_o (w_rd_error[i])
        );
    end

`ifdef IBEX_CSR_BANK_SCRUB_EN
    logic [CSR_BANK_IDX_W-1:0] r_scrub_idx;
    logic                      w_scrub_err;

    always_comb begin
        w_scrub_err = 1'b0;
        for (int i = 0; i < NumCsr; i++) begin
            if (r_scrub_idx == CSR_BANK_IDX_W'(i)) w_scrub_err = w_rd_error[i];
        end
    end

    assign w_scrub_idx = r_scrub_idx;
    assign w_scrub_hit = (req_i == 2'b00) && w_scrub_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_scrub_idx <= '0;
        end else if (req_i == 2'b00) begin
            r_scrub_idx <= (r_scrub_idx == CSR_BANK_IDX_W'(NumCsr - 1)) ? '0 : r_scrub_idx + 1'b1;
        end
    end
`else
    assign w_scrub_idx = '0;
    assign w_scrub_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 2'b00;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_gnt;
            r_rdata  <= w_any ? w_old : '0;
            r_err    <= w_any && (!w_addr_ok || w_old_err);
        end
    end

    // Index is captured only for the first alert; scrub and access never coincide
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_alert     <= 1'b0;
            r_alert_idx <= '0;
        end else if (!r_alert) begin
            if (w_any && w_old_err) begin
                r_alert     <= 1'b1;
                r_alert_idx <= w_addr;
            end else if (w_scrub_hit) begin
                r_alert     <= 1'b1;
                r_alert_idx <= w_scrub_idx;
            end
        end
    end

    assign gnt_o       = w_gnt;
    assign rvalid_o    = r_rvalid;
    assign rdata_o     = r_rdata;
    assign err_o       = r_err;
    assign alert_o     = r_alert;
    assign alert_idx_o = r_alert_idx;

endmodule

// File: tb/tb_ibex_csr_bank_ctrl.sv
// Directed self-checking bench for ibex_csr_bank_ctrl (8 x 32-bit bank).
module tb_ibex_csr_bank_ctrl;

    localparam logic [255:0] RV = {32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0,
                                   32'h1234_5678, 32'h0, 32'h0, 32'h0};

    logic            clk;
    logic            rst_n;
    logic [1:0]      req;
    logic [1:0][1:0] op;
    logic [1:0][4:0] addr;
    logic [1:0][31:0] wdata;
    logic [1:0]      gnt;
    logic [1:0]      rvalid;
    logic [31:0]     rdata;
    logic            err;
    logic            alert;
    logic [4:0]      alert_idx;

    int n_cmp = 0;
    int n_err = 0;

    ibex_csr_bank_ctrl #(
        .Width(32), .NumCsr(8), .ShadowCopy(1'b1), .ResetVals(RV)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .op_i(op), .addr_i(addr),
        .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
        .err_o(err), .alert_o(alert), .alert_idx_o(alert_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request from the chosen side and captures grant and response.
    task automatic do_access(input int who, input logic [1:0] o, input logic [4:0] a,
                             input logic [31:0] d, output logic [1:0] g,
                             output logic [1:0] rv, output logic [31:0] rd, output logic e);
        @(negedge clk);
        req = 2'b00; req[who] = 1'b1; op[who] = o; addr[who] = a; wdata[who] = d;
        #1 g = gnt;
        @(posedge clk);
        #1 rv = rvalid; rd = rdata; e = err;
        req = 2'b00;
    endtask

    task automatic apply_reset;
        @(negedge clk);
        req = 2'b00;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({gnt, rvalid, rdata, err, alert, alert_idx} !== 43'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got gnt=%b rvalid=%b rdata=%h err=%b alert=%b idx=%0d, want all 0",
                     gnt, rvalid, rdata, err, alert, alert_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read;
        logic [1:0] g, rv; logic [31:0] rd; logic e;
        do_access(0, 2'd0, 5'd3, 32'h0, g, rv, rd, e);
        n_cmp++;
        if (g !== 2'b01) begin n_err++; $display("FAIL read_gnt: got %b want 01", g); end
        n_cmp++;
        if (rv !== 2'b01 || rd !== 32'h1234_5678 || e !== 1'b0) begin
            n_err++;
            $display("FAIL read_resp: got rvalid=%b rdata=%h err=%b want 01/12345678/0", rv, rd, e);
        end
    endtask

    task automatic test_rmw;
        logic [1:0] g, rv; logic [31:0] rd; logic e;
        logic [1:0]  ops [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic [31:0] opd [4] = '{32'hA5A5_0000, 32'h0000_00FF, 32'hA500_0000, 32'h0};
        logic [31:0] exp [4] = '{32'h0, 32'hA5A5_0000, 32'hA5A5_00FF, 32'h00A5_00FF};
        for (int i = 0; i < 4; i++) begin
            do_access(0, ops[i], 5'd1, opd[i], g, rv, rd, e);
            n_cmp++;
            if (rv !== 2'b01 || rd !== exp[i] || e !== 1'b0) begin
                n_err++;
                $display("FAIL rmw_step%0d: got rvalid=%b rdata=%h err=%b want 01/%h/0", i, rv, rd, e, exp[i]);
            end
        end
    endtask

    task automatic test_bad_addr;
        logic [1:0] g, rv; logic [31:0] rd; logic e;
        do_access(1, 2'd1, 5'd9, 32'hFFFF_FFFF, g, rv, rd, e);
        n_cmp++;
        if (g !== 2'b10 || rv !== 2'b10 || rd !== 32'h0 || e !== 1'b1 || alert !== 1'b0) begin
            n_err++;
            $display("FAIL bad_addr: got gnt=%b rvalid=%b rdata=%h err=%b alert=%b want 10/10/0/1/0",
                     g, rv, rd, e, alert);
        end
        do_access(0, 2'd0, 5'd1, 32'h0, g, rv, rd, e);
        n_cmp++;
        if (rd !== 32'h00A5_00FF || e !== 1'b0) begin
            n_err++;
            $display("FAIL bad_addr_no_alias: got rdata=%h err=%b want 00a500ff/0", rd, e);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        req = 2'b01; op[0] = 2'd0; addr[0] = 5'd7;
        @(posedge clk);
        #1;
        n_cmp++;
        if (rvalid !== 2'b01 || rdata !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL mid_pre: got rvalid=%b rdata=%h want 01/deadbeef", rvalid, rdata);
        end
        rst_n = 1'b0;
        req = 2'b00;
        #1;
        n_cmp++;
        if (rvalid !== 2'b00) begin n_err++; $display("FAIL mid_in_reset: got rvalid=%b want 00", rvalid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (rvalid !== 2'b00) begin n_err++; $display("FAIL mid_after: got rvalid=%b want 00", rvalid); end
    endtask

    task automatic test_rr;
        logic [1:0] exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        @(negedge clk);
        req = 2'b11; op[0] = 2'd0; op[1] = 2'd0; addr[0] = 5'd0; addr[1] = 5'd3;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (gnt !== exp[i]) begin n_err++; $display("FAIL rr_gnt%0d: got %b want %b", i, gnt, exp[i]); end
            @(posedge clk);
            #1;
            n_cmp++;
            if (rvalid !== exp[i]) begin n_err++; $display("FAIL rr_rvalid%0d: got %b want %b", i, rvalid, exp[i]); end
            @(negedge clk);
        end
        req = 2'b00;
    endtask

    task automatic test_integrity;
        logic [1:0] g, rv; logic [31:0] rd; logic e;
        force dut.g_csr[2].u_csr.r_shadow = 32'h0;
        do_access(0, 2'd0, 5'd2, 32'h0, g, rv, rd, e);
        n_cmp++;
        if (e !== 1'b1 || alert !== 1'b1 || alert_idx !== 5'd2) begin
            n_err++;
            $display("FAIL integ_reg2: got err=%b alert=%b idx=%0d want 1/1/2", e, alert, alert_idx);
        end
        do_access(0, 2'd1, 5'd2, 32'h0000_0055, g, rv, rd, e);
        n_cmp++;
        if (e !== 1'b1) begin n_err++; $display("FAIL integ_wr_err: got err=%b want 1", e); end
        release dut.g_csr[2].u_csr.r_shadow;
        do_access(0, 2'd0, 5'd2, 32'h0, g, rv, rd, e);
        n_cmp++;
        if (rd !== 32'h0) begin n_err++; $display("FAIL integ_wr_suppressed: got rdata=%h want 0", rd); end
        force dut.g_csr[5].u_csr.r_shadow = 32'h0;
        do_access(0, 2'd0, 5'd5, 32'h0, g, rv, rd, e);
        n_cmp++;
        if (e !== 1'b1 || alert !== 1'b1 || alert_idx !== 5'd2) begin
            n_err++;
            $display("FAIL integ_first_only: got err=%b alert=%b idx=%0d want 1/1/2", e, alert, alert_idx);
        end
        release dut.g_csr[5].u_csr.r_shadow;
    endtask

    task automatic test_scrub;
        apply_reset();
        force dut.g_csr[6].u_csr.r_shadow = 32'h0;
        repeat (8) @(posedge clk);
        #1;
        n_cmp++;
`ifdef IBEX_CSR_BANK_SCRUB_EN
        if (alert !== 1'b1 || alert_idx !== 5'd6) begin
            n_err++;
            $display("FAIL scrub_alert: got alert=%b idx=%0d want 1/6", alert, alert_idx);
        end
`else
        if (alert !== 1'b0 || alert_idx !== 5'd0) begin
            n_err++;
            $display("FAIL scrub_off: got alert=%b idx=%0d want 0/0", alert, alert_idx);
        end
`endif
        release dut.g_csr[6].u_csr.r_shadow;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 2'b00;
        op    = '0;
        addr  = '0;
        wdata = '0;
        test_reset();
        test_read();
        test_rmw();
        test_bad_addr();
        test_reset_mid();
        test_rr();
        test_integrity();
        test_scrub();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
